// File: rtl/dcpu_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the dcpu memory bus.
// A registered grant is held until the slave acks; a watchdog forces an error ack if it never does.
module dcpu_bus_arbiter #(
  parameter int             AW       = 16,
  parameter int             DW       = 16,
  parameter int             TIMEOUT  = 15,
  parameter logic [DW-1:0]  ERR_DATA = DW'(16'hDEAD)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_dat,
  input  logic          i_m0_we,
  input  logic          i_m0_cs,
  output logic [DW-1:0] o_m0_dat,
  output logic          o_m0_ack,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_dat,
  input  logic          i_m1_we,
  input  logic          i_m1_cs,
  output logic [DW-1:0] o_m1_dat,
  output logic          o_m1_ack,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_dat,
  output logic          o_s_we,
  output logic          o_s_cs,
  input  logic [DW-1:0] i_s_dat,
  input  logic          i_s_ack,
  output logic [1:0]    o_grant,
  output logic          o_timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  // The counter holds the number of completed granted cycles, so the watchdog
  // fires on the TIMEOUT-th granted cycle, when the count reads TIMEOUT-1.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT0    = 2'd1,
    S_GNT1    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t         r_state;
  logic [1:0]     r_grant;
  logic           r_last;   // 1: m1 was served last
  logic [WDW-1:0] r_wdog;

  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_cs;
  logic           w_fire;
  logic           w_done;
  logic [DW-1:0]  w_rdat;

  assign w_gnt0 = (r_state == S_GNT0);
  assign w_gnt1 = (r_state == S_GNT1);

  always_comb begin
    w_cs     = 1'b0;
    o_s_addr = '0;
    o_s_dat  = '0;
    o_s_we   = 1'b0;
    if (w_gnt0) begin
      w_cs     = i_m0_cs;
      o_s_addr = i_m0_addr;
      o_s_dat  = i_m0_dat;
      o_s_we   = i_m0_we;
    end else if (w_gnt1) begin
      w_cs     = i_m1_cs;
      o_s_addr = i_m1_addr;
      o_s_dat  = i_m1_dat;
      o_s_we   = i_m1_we;
    end
  end

  // A real ack on the timeout cycle takes precedence over the watchdog.
  assign w_fire    = w_cs & ~i_s_ack & (r_wdog == WD_LAST);
  assign w_done    = w_cs & (i_s_ack | w_fire);
  assign w_rdat    = w_fire ? ERR_DATA : i_s_dat;

  assign o_s_cs    = w_cs & ~w_fire;
  assign o_timeout = w_fire;
  assign o_m0_ack  = w_gnt0 & w_done;
  assign o_m1_ack  = w_gnt1 & w_done;
  assign o_m0_dat  = w_gnt0 ? w_rdat : '0;
  assign o_m1_dat  = w_gnt1 ? w_rdat : '0;
  assign o_grant   = r_grant;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_wdog  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (i_m0_cs && (!i_m1_cs || r_last)) begin
            r_state <= S_GNT0;
            r_grant <= 2'b01;
          end else if (i_m1_cs) begin
            r_state <= S_GNT1;
            r_grant <= 2'b10;
          end
        end
        S_GNT0, S_GNT1: begin
          if (!w_cs || w_done) begin
            // An abort leaves the round-robin pointer untouched.
            if (w_cs) r_last <= w_gnt1;
            r_state <= S_RELEASE;
            r_grant <= 2'b00;
            r_wdog  <= '0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
          r_wdog  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
          r_wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Bench for dcpu_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_dcpu_bus_arbiter;

  localparam int TIMEOUT = 15;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat, i_s_dat;
  logic        i_m0_we, i_m0_cs, i_m1_we, i_m1_cs, i_s_ack;
  logic [15:0] o_m0_dat, o_m1_dat, o_s_addr, o_s_dat;
  logic        o_m0_ack, o_m1_ack, o_s_we, o_s_cs, o_timeout;
  logic [1:0]  o_grant;

  int n_chk  = 0;
  int n_pass = 0;

  dcpu_bus_arbiter #(.AW(16), .DW(16), .TIMEOUT(TIMEOUT), .ERR_DATA(16'hDEAD)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat), .i_m0_we(i_m0_we), .i_m0_cs(i_m0_cs),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack),
    .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat), .i_m1_we(i_m1_we), .i_m1_cs(i_m1_cs),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
    .o_s_addr(o_s_addr), .o_s_dat(o_s_dat), .o_s_we(o_s_we), .o_s_cs(o_s_cs),
    .i_s_dat(i_s_dat), .i_s_ack(i_s_ack),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: who owns the bus, whether a release gap is due,
  // how many granted cycles have elapsed, and who was served last.
  int mo_owner = -1;
  bit mo_cool  = 1'b0;
  int mo_held  = 0;
  int mo_last  = 1;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mo_owner = -1; mo_cool = 1'b0; mo_held = 0; mo_last = 1;
    end else if (mo_owner >= 0) begin
      automatic logic cs_x = (mo_owner == 0) ? i_m0_cs : i_m1_cs;
      automatic logic fire = cs_x && !i_s_ack && (mo_held + 1 == TIMEOUT);
      if (!cs_x || i_s_ack || fire) begin
        if (cs_x) mo_last = mo_owner;
        mo_owner = -1;
        mo_cool  = 1'b1;
      end else begin
        mo_held++;
      end
    end else if (mo_cool) begin
      mo_cool = 1'b0;
    end else begin
      mo_held = 0;
      if (i_m0_cs && i_m1_cs) mo_owner = 1 - mo_last;
      else if (i_m0_cs)       mo_owner = 0;
      else if (i_m1_cs)       mo_owner = 1;
    end
  end

  logic        e_cs, e_we, e_ack0, e_ack1, e_to, e_fire, e_csx;
  logic [15:0] e_addr, e_sdat, e_dat0, e_dat1;
  logic [1:0]  e_grant;
  logic        exp_ack0 = 1'b0, exp_ack1 = 1'b0;

  always @(negedge i_clk) begin
    e_cs = 0; e_we = 0; e_ack0 = 0; e_ack1 = 0; e_to = 0;
    e_addr = 0; e_sdat = 0; e_dat0 = 0; e_dat1 = 0; e_grant = 0;
    if (mo_owner >= 0) begin
      e_csx  = (mo_owner == 0) ? i_m0_cs : i_m1_cs;
      e_fire = e_csx && !i_s_ack && (mo_held + 1 == TIMEOUT);
      e_cs   = e_csx && !e_fire;
      e_to   = e_fire;
      e_addr = (mo_owner == 0) ? i_m0_addr : i_m1_addr;
      e_sdat = (mo_owner == 0) ? i_m0_dat  : i_m1_dat;
      e_we   = (mo_owner == 0) ? i_m0_we   : i_m1_we;
      if (mo_owner == 0) begin
        e_grant = 2'b01;
        e_ack0  = e_csx && (i_s_ack || e_fire);
        e_dat0  = e_fire ? 16'hDEAD : i_s_dat;
      end else begin
        e_grant = 2'b10;
        e_ack1  = e_csx && (i_s_ack || e_fire);
        e_dat1  = e_fire ? 16'hDEAD : i_s_dat;
      end
    end
    exp_ack0 = e_ack0;
    exp_ack1 = e_ack1;
    chk("cmp_s_cs",    o_s_cs,    e_cs);
    chk("cmp_s_addr",  o_s_addr,  e_addr);
    chk("cmp_s_dat",   o_s_dat,   e_sdat);
    chk("cmp_s_we",    o_s_we,    e_we);
    chk("cmp_m0_ack",  o_m0_ack,  e_ack0);
    chk("cmp_m0_dat",  o_m0_dat,  e_dat0);
    chk("cmp_m1_ack",  o_m1_ack,  e_ack1);
    chk("cmp_m1_dat",  o_m1_dat,  e_dat1);
    chk("cmp_grant",   o_grant,   e_grant);
    chk("cmp_timeout", o_timeout, e_to);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge i_clk);
  endtask

  task automatic mstep(input logic ackd, inout logic cs, inout logic [15:0] a,
                       inout logic [15:0] d, inout logic we);
    if (cs) begin
      if (ackd) begin
        if ($urandom_range(1, 0) == 1) begin
          a = 16'($urandom); d = 16'($urandom); we = 1'($urandom);
        end else begin
          cs = 1'b0;
        end
      end else if ($urandom_range(39, 0) == 0) begin
        cs = 1'b0;
      end
    end else if ($urandom_range(2, 0) == 0) begin
      cs = 1'b1; a = 16'($urandom); d = 16'($urandom); we = 1'($urandom);
    end
  endtask

  logic [1:0] seq [8];
  int         nseq;
  int         pct;

  initial begin
    i_reset = 1'b1;
    i_m0_addr = 0; i_m0_dat = 0; i_m0_we = 0; i_m0_cs = 0;
    i_m1_addr = 0; i_m1_dat = 0; i_m1_we = 0; i_m1_cs = 0;
    i_s_dat = 0; i_s_ack = 0;
    step(); smp();
    chk("reset_grant", o_grant, 2'b00);
    chk("reset_s_cs", o_s_cs, 1'b0);
    chk("reset_timeout", o_timeout, 1'b0);
    step(); i_reset = 1'b0;

    // m0 read, acked on the third granted cycle
    i_m0_cs = 1; i_m0_addr = 16'h0040; i_m0_we = 0;
    smp(); chk("a_req_grant", o_grant, 2'b00); chk("a_req_s_cs", o_s_cs, 1'b0);
    step(); smp();
    chk("a_g1_grant", o_grant, 2'b01); chk("a_g1_s_cs", o_s_cs, 1'b1);
    chk("a_g1_addr", o_s_addr, 16'h0040); chk("a_g1_ack", o_m0_ack, 1'b0);
    step(); smp(); chk("a_g2_grant", o_grant, 2'b01);
    step(); i_s_ack = 1; i_s_dat = 16'h1234;
    smp(); chk("a_g3_ack", o_m0_ack, 1'b1); chk("a_g3_dat", o_m0_dat, 16'h1234);
    chk("a_g3_grant", o_grant, 2'b01);
    step(); i_m0_cs = 0; i_s_ack = 0;
    smp(); chk("a_rel_grant", o_grant, 2'b00); chk("a_rel_s_cs", o_s_cs, 1'b0);
    step(); smp(); chk("a_idle_grant", o_grant, 2'b00);

    // simultaneous requests right after reset
    i_reset = 1; step(); step(); i_reset = 0;
    i_m0_cs = 1; i_m0_addr = 16'h0010; i_m0_we = 0;
    i_m1_cs = 1; i_m1_addr = 16'h0020; i_m1_dat = 16'hBEEF; i_m1_we = 1;
    step(); smp();
    chk("b_g0_grant", o_grant, 2'b01); chk("b_g0_addr", o_s_addr, 16'h0010);
    chk("b_g0_m1ack", o_m1_ack, 1'b0);
    step(); i_s_ack = 1; i_s_dat = 16'h1111;
    smp(); chk("b_m0_ack", o_m0_ack, 1'b1); chk("b_m0_m1ack", o_m1_ack, 1'b0);
    step(); i_m0_cs = 0; i_s_ack = 0;
    smp(); chk("b_rel_grant", o_grant, 2'b00);
    step(); smp(); chk("b_idle_grant", o_grant, 2'b00);
    step(); smp();
    chk("b_g1_grant", o_grant, 2'b10); chk("b_g1_we", o_s_we, 1'b1);
    chk("b_g1_addr", o_s_addr, 16'h0020); chk("b_g1_dat", o_s_dat, 16'hBEEF);
    chk("b_g1_m0ack", o_m0_ack, 1'b0);
    step(); i_s_ack = 1;
    smp(); chk("b_m1_ack", o_m1_ack, 1'b1);
    step(); i_m1_cs = 0; i_s_ack = 0; i_m1_we = 0;
    smp(); chk("b_end_grant", o_grant, 2'b00);
    step(); step();

    // fairness: both request continuously, slave acks every cycle
    i_m0_cs = 1; i_m1_cs = 1; i_s_ack = 1; nseq = 0;
    for (int c = 0; c < 40; c++) begin
      step(); smp();
      if (o_grant != 2'b00 && nseq < 8) begin
        seq[nseq] = o_grant;
        nseq++;
      end
    end
    chk("c_count", nseq, 8);
    for (int k = 0; k < 8; k++) chk("c_alternate", seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
    step(); i_m0_cs = 0; i_m1_cs = 0; i_s_ack = 0;
    repeat (3) step();

    // timeout on m1, then a normal m0 transfer
    i_m1_cs = 1; i_m1_addr = 16'h0030; i_m1_we = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      step(); smp();
      if (k == 1) chk("d_g1_grant", o_grant, 2'b10);
      if (k == TIMEOUT - 1) begin
        chk("d_pre_ack", o_m1_ack, 1'b0); chk("d_pre_to", o_timeout, 1'b0);
      end
      if (k == TIMEOUT) begin
        chk("d_to_ack", o_m1_ack, 1'b1); chk("d_to_dat", o_m1_dat, 16'hDEAD);
        chk("d_to_pulse", o_timeout, 1'b1); chk("d_to_s_cs", o_s_cs, 1'b0);
      end
    end
    step(); i_m1_cs = 0;
    smp(); chk("d_rel_grant", o_grant, 2'b00); chk("d_rel_to", o_timeout, 1'b0);
    step(); i_m0_cs = 1; i_m0_addr = 16'h0050; i_s_ack = 1; i_s_dat = 16'h7777;
    step(); smp();
    chk("d_next_ack", o_m0_ack, 1'b1); chk("d_next_dat", o_m0_dat, 16'h7777);
    step(); i_m0_cs = 0; i_s_ack = 0;
    step();

    // ack on the same cycle the watchdog would fire
    i_m0_cs = 1; i_m0_addr = 16'h0060;
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      if (k == TIMEOUT) begin i_s_ack = 1; i_s_dat = 16'h5555; end
      smp();
      if (k == TIMEOUT) begin
        chk("e_ack", o_m0_ack, 1'b1); chk("e_dat", o_m0_dat, 16'h5555);
        chk("e_to", o_timeout, 1'b0); chk("e_s_cs", o_s_cs, 1'b1);
      end
    end
    step(); i_m0_cs = 0; i_s_ack = 0;
    step();

    // abort mid-grant
    i_m0_cs = 1;
    step(); step(); i_m0_cs = 0;
    smp(); chk("f_s_cs", o_s_cs, 1'b0); chk("f_ack", o_m0_ack, 1'b0);
    chk("f_grant", o_grant, 2'b01);
    step(); smp(); chk("f_rel_grant", o_grant, 2'b00);
    step(); smp(); chk("f_idle_grant", o_grant, 2'b00); chk("f_idle_s_cs", o_s_cs, 1'b0);

    // asynchronous reset mid-grant
    step(); i_m0_cs = 1;
    step(); smp(); chk("g_pre_s_cs", o_s_cs, 1'b1);
    #2 i_reset = 1;
    #1 chk("g_rst_grant", o_grant, 2'b00); chk("g_rst_s_cs", o_s_cs, 1'b0);
    chk("g_rst_ack", o_m0_ack, 1'b0);
    i_m0_cs = 0;
    step(); i_reset = 0;

    // randomized traffic with varying slave responsiveness
    for (int seg = 0; seg < 15; seg++) begin
      case (seg % 4)
        0: pct = 35;
        1: pct = 0;
        2: pct = 70;
        default: pct = 10;
      endcase
      for (int c = 0; c < 200; c++) begin
        step();
        mstep(exp_ack0, i_m0_cs, i_m0_addr, i_m0_dat, i_m0_we);
        mstep(exp_ack1, i_m1_cs, i_m1_addr, i_m1_dat, i_m1_we);
        i_s_ack = ($urandom_range(99, 0) < pct);
        i_s_dat = 16'($urandom);
      end
    end
    step(); i_m0_cs = 0; i_m1_cs = 0; i_s_ack = 0;
    repeat (3) step();
    smp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
